// File: rtl/ifetch_queue_pkg.sv
// Shared constants and the queue entry layout for the instruction prefetch queue.
package ifetch_queue_pkg;

  localparam int          DEPTH_DEF    = 4;
  localparam int          ENTRY_W      = 64;
  localparam logic [31:0] RESET_PC_DEF = 32'd0;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle: pipeline redirect, instruction memory port and decode handshake.
interface ifetch_queue_if;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc4;
  logic        inst_ready;

  modport master (
    output redirect, redirect_pc, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc4
  );

  modport slave (
    input  redirect, redirect_pc, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc4
  );

endinterface

// File: rtl/ifetch_queue_fetch_fifo.sv
// Synchronous FIFO of fetched entries; flush empties it in one cycle, head is read combinationally.
module fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  entry_t        wr_data,
  output entry_t        head,
  output logic [CW-1:0] count
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign head = entry_t'(mem[rd_ptr]);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential fetches against a credit limit and
// buffers responses for decode; a redirect flushes everything and restarts fetch.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic          inflight;
  logic [CW-1:0] count;
  logic          credit;
  logic          req;
  logic          valid;
  logic          push;
  logic          pop;
  entry_t        wr_data;
  entry_t        head;

  // An in-flight response already owns a slot, so it counts against the credit.
  assign credit = (int'(count) + int'(inflight)) < DEPTH;
  assign req    = rst_n & ~bus.redirect & credit;
  assign valid  = (count != '0);

  // A redirect in the response cycle cancels the write; the fifo flush covers the rest.
  assign push    = inflight & ~bus.redirect;
  assign pop     = valid & bus.inst_ready & ~bus.redirect;
  assign wr_data = '{pc4: req_addr + 32'd4, inst: bus.imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= req;
      if (bus.redirect) begin
        fetch_pc <= bus.redirect_pc;
      end else if (req) begin
        req_addr <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (bus.redirect),
    .wr_data (wr_data),
    .head    (head),
    .count   (count)
  );

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = valid;
  assign bus.inst       = head.inst;
  assign bus.inst_pc4   = head.pc4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a one-cycle-latency memory model returns addr>>2,
// a scoreboard queue holds expected pops, and a monitor checks every accepted head.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  entry_t exp_q[$];
  entry_t sb_e;
  logic        pend      = 1'b0;
  logic [31:0] pend_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_entry(input logic [31:0] addr);
    exp_q.push_back('{pc4: addr + 32'd4, inst: addr >> 2});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic obs();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    step();
    rst_n          = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect   = 1'b0;
    #1;
    check("rst_valid", bus.inst_valid, 1'b0);
    check("rst_req", bus.imem_req, 1'b0);
    repeat (2) step();
    check("rst_addr", bus.imem_addr, 32'd0);
    check("sb_drain", exp_q.size(), 0);
  endtask

  // Memory model: data for a request sampled in cycle k is presented in cycle k+1.
  always @(negedge clk) begin
    bus.imem_rdata = pend ? (pend_addr >> 2) : 32'hDEAD_BEEF;
    pend           = bus.imem_req;
    pend_addr      = bus.imem_addr;
  end

  always @(negedge clk) begin
    if (rst_n && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: popped pc4=%h inst=%h but nothing expected", bus.inst_pc4, bus.inst);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_pc4", bus.inst_pc4, sb_e.pc4);
        check("sb_inst", bus.inst, sb_e.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_ready  = 1'b0;
    bus.imem_rdata  = '0;

    // Reset state
    repeat (2) step();
    check("por_req", bus.imem_req, 1'b0);
    check("por_valid", bus.inst_valid, 1'b0);
    check("por_addr", bus.imem_addr, 32'd0);

    // Streaming with decode always ready
    for (int k = 0; k < 8; k++) expect_entry(32'(4 * k));
    step(); rst_n = 1'b1; bus.inst_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      obs();
      check("stream_req", bus.imem_req, 1'b1);
      check("stream_addr", bus.imem_addr, 32'(4 * c));
      check("stream_valid", bus.inst_valid, (c >= 2) ? 1'b1 : 1'b0);
      if (c >= 2) check("stream_pc4", bus.inst_pc4, 32'(4 * (c - 1)));
    end
    apply_reset();

    // Decode stalled: queue fills, then drains and fetch resumes
    for (int k = 0; k < 4; k++) expect_entry(32'(4 * k));
    step(); rst_n = 1'b1; bus.inst_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      if (c == 8) bus.inst_ready = 1'b1;
      obs();
      if (c < 4) begin
        check("fill_req", bus.imem_req, 1'b1);
        check("fill_addr", bus.imem_addr, 32'(4 * c));
      end else if (c < 9) begin
        check("full_noreq", bus.imem_req, 1'b0);
      end else if (c < 11) begin
        check("resume_req", bus.imem_req, 1'b1);
        check("resume_addr", bus.imem_addr, 32'(16 + 4 * (c - 9)));
      end
      if (c == 7) check("full_valid", bus.inst_valid, 1'b1);
    end
    apply_reset();

    // Redirect with three entries queued and a response in flight
    expect_entry(32'h100); expect_entry(32'h104); expect_entry(32'h108);
    step(); rst_n = 1'b1; bus.inst_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      if (c == 4) begin bus.redirect = 1'b1; bus.redirect_pc = 32'h100; end
      if (c == 5) begin bus.redirect = 1'b0; bus.inst_ready = 1'b1; end
      obs();
      case (c)
        4: begin
          check("redir_had_entries", bus.inst_valid, 1'b1);
          check("redir_noreq", bus.imem_req, 1'b0);
        end
        5: begin
          check("redir_flushed", bus.inst_valid, 1'b0);
          check("redir_req", bus.imem_req, 1'b1);
          check("redir_addr", bus.imem_addr, 32'h100);
        end
        6: check("redir_n2_valid", bus.inst_valid, 1'b0);
        7: begin
          check("redir_n3_valid", bus.inst_valid, 1'b1);
          check("redir_n3_pc4", bus.inst_pc4, 32'h104);
        end
        default: ;
      endcase
    end
    apply_reset();

    // Back-to-back redirects: the later target wins
    expect_entry(32'h300); expect_entry(32'h304); expect_entry(32'h308);
    step(); rst_n = 1'b1; bus.inst_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      if (c == 1) begin bus.redirect = 1'b1; bus.redirect_pc = 32'h200; end
      if (c == 2) bus.redirect_pc = 32'h300;
      if (c == 3) bus.redirect = 1'b0;
      obs();
      case (c)
        0: check("dbl_first_addr", bus.imem_addr, 32'd0);
        2: check("dbl_noreq", bus.imem_req, 1'b0);
        3: begin
          check("dbl_req", bus.imem_req, 1'b1);
          check("dbl_addr", bus.imem_addr, 32'h300);
        end
        4: check("dbl_n3_valid", bus.inst_valid, 1'b0);
        5: begin
          check("dbl_n4_valid", bus.inst_valid, 1'b1);
          check("dbl_n4_pc4", bus.inst_pc4, 32'h304);
        end
        default: ;
      endcase
    end
    apply_reset();

    // Fetch address wraps past the top of the address space
    expect_entry(32'hFFFF_FFF8); expect_entry(32'hFFFF_FFFC); expect_entry(32'h0);
    step(); rst_n = 1'b1; bus.inst_ready = 1'b1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      if (c == 1) bus.redirect = 1'b0;
      obs();
      case (c)
        2: check("wrap_addr_fc", bus.imem_addr, 32'hFFFF_FFFC);
        3: begin
          check("wrap_addr_0", bus.imem_addr, 32'h0);
          check("wrap_pc4_fc", bus.inst_pc4, 32'hFFFF_FFFC);
        end
        4: check("wrap_pc4_0", bus.inst_pc4, 32'h0);
        default: ;
      endcase
    end
    apply_reset();

    // Reset pulse with a full queue
    expect_entry(32'h0); expect_entry(32'h4);
    step(); rst_n = 1'b1; bus.inst_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      obs();
    end
    check("full_before_rst", bus.inst_valid, 1'b1);
    step(); rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.inst_valid, 1'b0);
    check("midrst_req", bus.imem_req, 1'b0);
    repeat (2) step();
    step(); rst_n = 1'b1; bus.inst_ready = 1'b1;
    obs();
    check("post_rst_req", bus.imem_req, 1'b1);
    check("post_rst_addr", bus.imem_addr, 32'd0);
    check("post_rst_valid", bus.inst_valid, 1'b0);
    step(); obs();
    step(); obs();
    check("post_rst_pc4", bus.inst_pc4, 32'h4);
    step(); obs();
    step(); bus.inst_ready = 1'b0;
    obs();
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
